// File: rtl/tile_ser_pkg.sv
// tile_ser_pkg: shared word width default, bank state type and physical-row helper
package tile_ser_pkg;
  localparam int DEFAULT_DW = 16;
  typedef enum logic {BANK_EMPTY, BANK_FULL} bank_state_e;
  function automatic int phys_row(input int row_cnt, input logic rev, input int poy);
    return rev ? poy - 1 - row_cnt : row_cnt;
  endfunction
endpackage

// File: rtl/tile_ser_bank.sv
// tile_ser_bank: one ping-pong slot; ports: wr_en/wr_tile/wr_rev capture, clr frees, row_cnt selects rd_row/rd_idx, full flag; TILE_SER_RELU_EN clamps negatives on capture
module tile_ser_bank import tile_ser_pkg::*; #(
  parameter int POX = 3,
  parameter int POY = 3,
  parameter int DW = DEFAULT_DW,
  parameter int IW = (POY > 1) ? $clog2(POY) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic                          clr,
  input  logic [POY-1:0][POX-1:0][DW-1:0] wr_tile,
  input  logic                          wr_rev,
  input  logic [IW-1:0]                 row_cnt,
  output logic                          full,
  output logic [POX-1:0][DW-1:0]        rd_row,
  output logic [IW-1:0]                 rd_idx
);
  bank_state_e state, state_nx;
  logic rev;
  logic [POY-1:0][POX-1:0][DW-1:0] tile, wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= BANK_EMPTY;
    else state <= state_nx;
  always_comb begin
    state_nx = wr_en ? BANK_FULL : clr ? BANK_EMPTY : state;
    full = state == BANK_FULL;
    rd_idx = IW'(phys_row(int'(row_cnt), rev, POY));
    rd_row = tile[rd_idx];
  end
`ifdef TILE_SER_RELU_EN
  always_comb begin
    wr_data = wr_tile;
    for (int y = 0; y < POY; y++)
      for (int x = 0; x < POX; x++)
        wr_data[y][x] = wr_tile[y][x][DW-1] ? '0 : wr_tile[y][x];
  end
`else
  assign wr_data = wr_tile;
`endif
  always_ff @(posedge clk)
    if (wr_en) begin
      tile <= wr_data;
      rev <= wr_rev;
    end
endmodule

// File: rtl/tile_row_serializer.sv
// tile_row_serializer: accepts POYxPOX tiles (in_*) into a two-bank ping-pong buffer and emits them row by row (out_*), forward or reverse; optional TILE_SER_RELU_EN
module tile_row_serializer import tile_ser_pkg::*; #(
  parameter int POX = 3,
  parameter int POY = 3,
  parameter int DW = DEFAULT_DW
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [POY-1:0][POX-1:0][DW-1:0]   in_tile,
  input  logic                              in_rev,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [POX-1:0][DW-1:0]            out_row,
  output logic [((POY > 1) ? $clog2(POY) : 1)-1:0] out_row_idx,
  output logic                              out_last,
  output logic                              out_valid,
  input  logic                              out_ready
);
  localparam int IW = (POY > 1) ? $clog2(POY) : 1;
  logic wr_ptr, rd_ptr, alive, in_hs, out_hs, last_row;
  logic [IW-1:0] row_cnt;
  logic [1:0] full, wr_en, clr;
  logic [1:0][POX-1:0][DW-1:0] rows;
  logic [1:0][IW-1:0] idxs;
  for (genvar i = 0; i < 2; i++) begin : g_bank
    tile_ser_bank #(.POX(POX), .POY(POY), .DW(DW), .IW(IW)) u_bank (
      .clk(clk),
      .rst(rst),
      .wr_en(wr_en[i]),
      .clr(clr[i]),
      .wr_tile(in_tile),
      .wr_rev(in_rev),
      .row_cnt(row_cnt),
      .full(full[i]),
      .rd_row(rows[i]),
      .rd_idx(idxs[i])
    );
  end
  // alive keeps in_ready low while rst is held and for the edge that releases it
  always_comb begin
    in_ready = alive & ~full[wr_ptr];
    out_valid = full[rd_ptr];
    last_row = row_cnt == IW'(POY - 1);
    out_last = out_valid & last_row;
    out_row = out_valid ? rows[rd_ptr] : '0;
    out_row_idx = out_valid ? idxs[rd_ptr] : '0;
    in_hs = in_valid & in_ready;
    out_hs = out_valid & out_ready;
    wr_en = {in_hs & wr_ptr, in_hs & ~wr_ptr};
    clr = {out_hs & last_row & rd_ptr, out_hs & last_row & ~rd_ptr};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      alive <= 1'b0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      row_cnt <= '0;
    end else begin
      alive <= 1'b1;
      if (in_hs) wr_ptr <= ~wr_ptr;
      if (out_hs) begin
        row_cnt <= last_row ? '0 : row_cnt + IW'(1);
        if (last_row) rd_ptr <= ~rd_ptr;
      end
    end
endmodule

// File: tb/tb_tile_row_serializer.sv
// tb_tile_row_serializer: directed and random-stall checks against a row-queue model of tile_row_serializer
module tb_tile_row_serializer;
  localparam int POX = 3, POY = 3, DW = 16;
  typedef logic [POX-1:0][DW-1:0] row_t;
  typedef logic [POY-1:0][POX-1:0][DW-1:0] tile_t;
  typedef struct { row_t row; int idx; logic last; } exp_t;
  logic clk = 0, rst = 0, in_rev = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_last, out_valid;
  tile_t in_tile = '0;
  row_t out_row;
  logic [1:0] out_row_idx;
  int tests = 0, fails = 0;
  exp_t q[$];
  logic stalled = 0, done = 0;
  row_t held_row;
  logic [1:0] held_idx;
  tile_t t0, t1, t2, tr;
  tile_row_serializer #(.POX(POX), .POY(POY), .DW(DW)) dut (
    .clk(clk), .rst(rst), .in_tile(in_tile), .in_rev(in_rev), .in_valid(in_valid),
    .in_ready(in_ready), .out_row(out_row), .out_row_idx(out_row_idx),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic row_t mrow(input row_t r);
    mrow = r;
`ifdef TILE_SER_RELU_EN
    for (int x = 0; x < POX; x++) if (r[x][DW-1]) mrow[x] = '0;
`endif
  endfunction
  function automatic tile_t mk_tile(input int base);
    for (int y = 0; y < POY; y++)
      for (int x = 0; x < POX; x++) mk_tile[y][x] = DW'(base + 16 * y + x);
  endfunction
  always @(negedge clk) begin : cmp
    exp_t e;
    if (rst) begin
      q.delete();
      stalled = 0;
    end else begin
      if (in_valid && in_ready)
        for (int k = 0; k < POY; k++) begin
          e.idx = in_rev ? POY - 1 - k : k;
          e.row = mrow(in_tile[e.idx]);
          e.last = k == POY - 1;
          q.push_back(e);
        end
      if (stalled) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_row", out_row, held_row);
        chk("stall_idx", out_row_idx, held_idx);
      end
      if (out_valid) begin
        if (q.size() == 0) chk("no_stale_row", out_valid, 0);
        else begin
          chk("sb_row", out_row, q[0].row);
          chk("sb_idx", out_row_idx, q[0].idx);
          chk("sb_last", out_last, q[0].last);
          if (out_ready) void'(q.pop_front());
        end
      end else chk("last_without_valid", out_last, 0);
      stalled = out_valid && !out_ready;
      held_row = out_row;
      held_idx = out_row_idx;
    end
  end
  task automatic send_tile(input tile_t t, input logic rev);
    int n = 0;
    in_tile = t;
    in_rev = rev;
    in_valid = 1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    chk("accept", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  task automatic expect_row(input string name, input int idx, input row_t row, input logic last);
    @(negedge clk);
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_idx"}, out_row_idx, idx);
    chk({name, "_row"}, out_row, row);
    chk({name, "_last"}, out_last, last);
  endtask
  task automatic drain();
    int n = 0;
    out_ready = 1;
    while ((q.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", q.size(), 0);
    chk("drain_valid_low", out_valid, 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at 400us, required finish");
    $fatal(1, "watchdog");
  end
  initial begin
    #2 rst = 1;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_row", out_row, 0);
    chk("rst_out_idx", out_row_idx, 0);
    chk("rst_out_last", out_last, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1 out_ready = 1;
    send_tile(mk_tile(0), 0);
    expect_row("fwd0", 0, 48'h0002_0001_0000, 0);
    expect_row("fwd1", 1, 48'h0012_0011_0010, 0);
    expect_row("fwd2", 2, 48'h0022_0021_0020, 1);
    @(negedge clk);
    chk("fwd_done_valid", out_valid, 0);
    @(posedge clk);
    #1 send_tile(mk_tile(0), 1);
    expect_row("rev0", 2, 48'h0022_0021_0020, 0);
    expect_row("rev1", 1, 48'h0012_0011_0010, 0);
    expect_row("rev2", 0, 48'h0002_0001_0000, 1);
    drain();
    t0 = mk_tile(256);
    t1 = mk_tile(512);
    t2 = mk_tile(768);
    out_ready = 0;
    in_tile = t0;
    in_rev = 0;
    in_valid = 1;
    @(negedge clk);
    chk("t0_ready", in_ready, 1);
    @(posedge clk);
    #1 in_tile = t1;
    in_rev = 1;
    @(negedge clk);
    chk("t1_ready", in_ready, 1);
    @(posedge clk);
    #1 in_tile = t2;
    in_rev = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("both_full_ready", in_ready, 0);
      chk("stall_t0_row0", out_row, 48'h0102_0101_0100);
    end
    @(posedge clk);
    #1 out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ready_before_free", in_ready, 0);
    end
    @(negedge clk);
    chk("ready_after_free", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 0;
    drain();
    done = 0;
    fork
      begin
        for (int n = 0; n < 50; n++) begin
          for (int y = 0; y < POY; y++)
            for (int x = 0; x < POX; x++) tr[y][x] = DW'($urandom);
          send_tile(tr, 1'($urandom_range(0, 1)));
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();
    out_ready = 0;
    send_tile(t0, 0);
    send_tile(t1, 0);
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    @(negedge clk);
    chk("mid_drain_idx", out_row_idx, 1);
    #1 rst = 1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_row", out_row, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_last", out_last, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_release_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_no_stale", out_valid, 0);
    end
    @(posedge clk);
    #1 send_tile(t2, 0);
    expect_row("recover0", 0, 48'h0302_0301_0300, 0);
    drain();
    tr = mk_tile(0);
    tr[0][0] = 16'h8001;
    tr[0][1] = 16'h7FFF;
    send_tile(tr, 0);
`ifdef TILE_SER_RELU_EN
    expect_row("relu0", 0, 48'h0002_7FFF_0000, 0);
`else
    expect_row("relu0", 0, 48'h0002_7FFF_8001, 0);
`endif
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tile_row_serializer.md
# tile_row_serializer

Parametrised row serializer between the MAC array and the output writeback path. It accepts a complete POY×POX tile of MAC results through a valid/ready handshake and stores it in a two-entry ping-pong buffer. It then emits the tile one row of POX words per handshake on a valid/ready output stream, in forward or reverse row order. Because of the ping-pong buffer, the MAC array can deliver the next tile while the current one drains.

## Interface
- POX, 3: words per row (output width in words), ≥1
- POY, 3: rows per tile, ≥1
- DW, 16: word width in bits, ≥2
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_tile  in  [POY-1:0][POX-1:0][DW-1:0]  MAC result tile; row index = first dimension
- in_rev  in  1  row order for this tile (0: row 0 first, 1: row POY-1 first); sampled with in_tile
- in_valid  in  1  tile present
- in_ready  out  1  buffer slot free; reset 0 while rst, 1 after
- out_row  out  [POX-1:0][DW-1:0]  current row; reset 0
- out_row_idx  out  $clog2(POY) bits (min 1)  physical row index of out_row; reset 0
- out_last  out  1  out_row is the final row of its tile; reset 0
- out_valid  out  1  out_row valid; reset 0
- out_ready  in  1  downstream accepts row

## Operation
- The buffer has two banks, each holding a tile, its rev flag and a full flag. wr_ptr and rd_ptr are 1-bit pointers; row_cnt counts 0..POY-1.
- Bank states are EMPTY and FULL.
  - EMPTY→FULL on an input handshake (in_valid & in_ready) into bank[wr_ptr]. The tile and in_rev are captured, and wr_ptr toggles.
  - FULL→EMPTY on the output handshake of the final row of bank[rd_ptr]. rd_ptr toggles and row_cnt clears.
- Read side:
  - out_valid = full[rd_ptr].
  - Physical row = row_cnt when rev = 0, and POY-1-row_cnt when rev = 1.
  - out_row is that physical row of bank[rd_ptr]. out_row_idx is the physical row.
  - out_last = (row_cnt == POY-1) & out_valid.
  - Each output handshake (out_valid & out_ready) advances row_cnt. On the last row it wraps to 0.
- in_ready = !full[wr_ptr]. Both banks full means in_ready = 0. Both empty means out_valid = 0.
- Tiles are emitted strictly in acceptance order. No tile is dropped or duplicated.
- When out_valid is high and out_ready is low, out_row, out_row_idx and out_last hold stable.
- If POY = 1, every row is last, and in_rev has no effect.
- Values pass through unmodified unless the ReLU feature below is compiled in.
- Reset mid-operation clears both full flags, both pointers and row_cnt. Buffered data is discarded. Outputs take their reset values.

## Timing
- Input handshake at edge N gives out_valid = 1 after edge N (one-cycle latency) if the read bank was empty.
- Throughput is one row per cycle while out_ready = 1. A tile drains in POY cycles.
- Sustained input rate is one tile per POY cycles with no bubbles between tiles.
- There is no combinational path from out_ready to in_ready, or from in_valid to out_valid.
  - A bank freed by the last-row handshake at edge N raises in_ready after edge N, not before it.
- Simultaneous input and output handshakes on different banks in the same cycle are both honoured.
- out_row and out_row_idx are muxed from registered bank state. No input reaches any output combinationally.

## Configuration
- TILE_SER_RELU_EN defined: a word with MSB = 1 (negative, two's complement) is emitted as 0; other words pass unchanged. The clamp is applied at capture, so buffer storage holds clamped values.
- TILE_SER_RELU_EN undefined: words are emitted bit-exact. No clamp logic exists.

## Structure
- Shared package tile_ser_pkg holds:
  - DEFAULT_DW = 16
  - the bank state enum {BANK_EMPTY, BANK_FULL}
  - function phys_row(row_cnt, rev, poy)
- One sub-module, tile_ser_bank, instantiated twice. It contains:
  - tile storage, rev flag and full flag
  - the optional ReLU clamp on write
  - the row-select mux
- Top level holds wr_ptr, rd_ptr, row_cnt and the handshake logic.

## Test plan
- Reset, then one tile with word(y,x) = 16·y+x, in_rev = 0, out_ready held 1. Required response:
  - 3 rows on consecutive cycles, starting one cycle after acceptance, with idx 0,1,2.
  - Row 1 = {18,17,16}.
  - out_last only on idx 2.
- Same tile with in_rev = 1. Required: idx order 2,1,0, and out_last on idx 0.
- Three tiles offered back-to-back with out_ready = 0. Required:
  - The first two are accepted; in_ready stays 0 after that.
  - out_row stays stable while stalled.
  - After release: 9 rows in order T0,T1,T2, and in_ready rises one cycle after T0's last-row handshake.
- Random out_ready stalls over 50 tiles. Required: scoreboard shows every row in order, exactly once.
- Assert rst mid-drain (row 1 of T0, T1 queued). Required:
  - Immediately: out_valid = 0, out_row = 0, in_ready = 0.
  - After release: in_ready = 1, and no stale rows appear.
- With TILE_SER_RELU_EN: a tile containing 16'h8001 and 16'h7FFF. Required output: 0 and 16'h7FFF. Without the macro, both words are emitted unchanged.
